// File: rtl/button_parser_pkg.sv
// Shared defaults and width helper for the push-button conditioning block.
package button_parser_pkg;

  localparam int DEF_WIDTH          = 4;
  localparam int DEF_SAMPLE_CNT_MAX = 62_500;
  localparam int DEF_PULSE_CNT_MAX  = 200;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// WIDTH-wide rising-edge detector: registered one-cycle pulse per 0->1 of each input bit.
module edge_detector #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] pulse
);

  logic [W-1:0] level_q;
  logic [W-1:0] pulse_q, pulse_d;

  always_comb begin
    pulse_d = level & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      level_q <= level;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/button_parser.sv
// Raw push-buttons -> synchronized, debounced levels plus one-cycle press pulses.
module button_parser
  import button_parser_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] buttons_raw,
  output logic [WIDTH-1:0] buttons_level,
  output logic [WIDTH-1:0] buttons_pulse
);

  localparam int TW = cnt_w(SAMPLE_CNT_MAX);
  localparam int SW = cnt_w(PULSE_CNT_MAX + 1);

  if (SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1) begin : g_param_chk
    $error("button_parser: SAMPLE_CNT_MAX must be >= 2 and PULSE_CNT_MAX >= 1");
  end

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [TW-1:0]            tmr_q, tmr_d;
  logic                     sample_tick;
  logic [WIDTH-1:0][SW-1:0] sat_q, sat_d;

  // Timer is shared: every button is sampled on the same tick.
  always_comb begin
    sample_tick = (tmr_q == TW'(SAMPLE_CNT_MAX - 1));
    tmr_d       = sample_tick ? '0 : tmr_q + 1'b1;
  end

  // A single low sample restarts qualification; counts saturate, never wrap.
  always_comb begin
    sat_d         = sat_q;
    buttons_level = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!sync2_q[i])
        sat_d[i] = '0;
      else if (sample_tick && sat_q[i] != SW'(PULSE_CNT_MAX))
        sat_d[i] = sat_q[i] + 1'b1;
      buttons_level[i] = (sat_q[i] == SW'(PULSE_CNT_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tmr_q   <= '0;
      sat_q   <= '0;
    end else begin
      sync1_q <= buttons_raw;
      sync2_q <= sync1_q;
      tmr_q   <= tmr_d;
      sat_q   <= sat_d;
    end
  end

  edge_detector #(.W(WIDTH)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (buttons_level),
    .pulse (buttons_pulse)
  );

endmodule

// File: tb/tb_button_parser.sv
// Scoreboard bench: stimulus queues expected pulses with cycle windows, a monitor checks them.
module tb_button_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] buttons_raw = 4'h0;
  logic [3:0] buttons_level;
  logic [3:0] buttons_pulse;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] val;
    int         lo;
    int         hi;
  } exp_t;
  exp_t expq[$];

  logic [3:0] lvl_d1 = 4'h0, lvl_d2 = 4'h0;

  button_parser #(.WIDTH(4), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buttons_raw   (buttons_raw),
    .buttons_level (buttons_level),
    .buttons_pulse (buttons_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Press seen at negedge of cycle c: sync2 high after edge c+2, first tick within
  // 4 edges, two more ticks 8 edges later, pulse one edge after that.
  task automatic expect_press(input logic [3:0] v);
    expq.push_back('{val: v, lo: cyc + 12, hi: cyc + 15});
  endtask

  // Monitor: every nonzero pulse must match the head expectation in value and timing.
  always @(negedge clk) begin
    exp_t e;
    if (buttons_pulse != 4'h0) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse", buttons_pulse, 4'h0);
      end else begin
        e = expq.pop_front();
        chk("pulse_value", buttons_pulse, e.val);
        chk_rng("pulse_cycle", cyc, e.lo, e.hi);
        chk("level_rose_one_before", lvl_d1 & ~lvl_d2 & e.val, e.val);
      end
    end else if (expq.size() != 0 && cyc > expq[0].hi) begin
      e = expq.pop_front();
      chk("pulse_timeout", buttons_pulse, e.val);
    end
    lvl_d2 = lvl_d1;
    lvl_d1 = buttons_level;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r;

  initial begin
    // 1: reset with all buttons pressed, then idle
    buttons_raw = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("reset_level", buttons_level, 4'h0);
      chk("reset_pulse", buttons_pulse, 4'h0);
    end
    rst_n = 1'b1;
    buttons_raw = 4'h0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_level", buttons_level, 4'h0);
    end

    // 2: single clean press on bit 0, held
    buttons_raw = 4'b0001;
    expect_press(4'b0001);
    wait_cyc(25);
    chk("held0_level", buttons_level, 4'b0001);

    // 3: bouncing bit 1 never qualifies, then a clean hold does
    for (int k = 0; k < 14; k++) begin
      buttons_raw[1] = ~buttons_raw[1];
      wait_cyc(3);
    end
    chk("bounce_level", buttons_level, 4'b0001);
    buttons_raw[1] = 1'b1;
    expect_press(4'b0010);
    wait_cyc(25);
    chk("held01_level", buttons_level, 4'b0011);
    buttons_raw = 4'h0;
    wait_cyc(10);
    chk("release01_level", buttons_level, 4'h0);

    // 4: long hold on bit 2, release, press again
    buttons_raw = 4'b0100;
    expect_press(4'b0100);
    wait_cyc(1000);
    chk("long_hold_level", buttons_level, 4'b0100);
    buttons_raw = 4'h0;
    wait_cyc(3);
    chk("release2_level_3cyc", buttons_level, 4'h0);
    wait_cyc(10);
    buttons_raw = 4'b0100;
    expect_press(4'b0100);
    wait_cyc(25);
    buttons_raw = 4'h0;
    wait_cyc(10);

    // 5: simultaneous press on bits 0 and 3
    buttons_raw = 4'b1001;
    expect_press(4'b1001);
    wait_cyc(25);
    chk("simul_level", buttons_level, 4'b1001);
    buttons_raw = 4'h0;
    wait_cyc(10);

    // 6: reset while bit 3 is two ticks into qualification
    buttons_raw = 4'b1000;
    wait_cyc(10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midqual_reset_level", buttons_level, 4'h0);
    chk("midqual_reset_pulse", buttons_pulse, 4'h0);
    rst_n = 1'b1;
    r = cyc;
    // timer restarts at 0: ticks on edges r+4, r+8, r+12; pulse after edge r+13
    expq.push_back('{val: 4'b1000, lo: r + 13, hi: r + 13});
    wait_cyc(25);
    chk("requal_level", buttons_level, 4'b1000);
    buttons_raw = 4'h0;
    wait_cyc(10);

    chk_rng("pending_expectations", expq.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
